// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: coin codes, coin values,
// FSM state encoding and the greedy change-coin helpers.
package vend_pkg;
  localparam int CREDIT_W = 5;
  typedef logic [CREDIT_W-1:0] credit_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_5    = 2'b10;
  localparam logic [1:0] COIN_10   = 2'b11;

  localparam credit_t VAL_1  = 5'd1;
  localparam credit_t VAL_5  = 5'd5;
  localparam credit_t VAL_10 = 5'd10;

  typedef enum logic [1:0] {IDLE, VEND, CHANGE, CLEAR} state_e;

  // Largest coin not exceeding the amount still owed, so remaining never underflows.
  function automatic logic [1:0] greedy_coin(input credit_t rem);
    if (rem >= VAL_10)     return COIN_10;
    else if (rem >= VAL_5) return COIN_5;
    else if (rem >= VAL_1) return COIN_1;
    else                   return COIN_NONE;
  endfunction

  function automatic credit_t coin_value(input logic [1:0] c);
    case (c)
      COIN_10: return VAL_10;
      COIN_5:  return VAL_5;
      COIN_1:  return VAL_1;
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/vend_if.sv
// Dispenser and change-hopper handshakes; the controller is the master side.
interface vend_if;
  logic       vend_req;
  logic [1:0] vend_item;
  logic       vend_ack;
  logic       change_valid;
  logic [1:0] change_coin;
  logic       change_ready;

  modport master (output vend_req, vend_item, change_valid, change_coin,
                  input  vend_ack, change_ready);
  modport slave  (input  vend_req, vend_item, change_valid, change_coin,
                  output vend_ack, change_ready);
endinterface

// File: rtl/change_payout.sv
// Holds the amount still owed and pays it out one greedy coin per valid/ready transfer.
module change_payout
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  credit_t    load_val_i,
  input  logic       en_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [1:0] coin_o,
  output logic       done_o
);
  credit_t    rem_q, rem_d;
  logic       valid_q;
  logic [1:0] coin_q;

  // Amount owed after this cycle's transfer (if any) lands.
  assign rem_d  = (valid_q && ready_i) ? rem_q - coin_value(coin_q) : rem_q;
  assign done_o = (rem_d == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q   <= '0;
      valid_q <= 1'b0;
      coin_q  <= COIN_NONE;
    end else if (load_i) begin
      rem_q   <= load_val_i;
      valid_q <= 1'b0;
      coin_q  <= COIN_NONE;
    end else if (en_i) begin
      rem_q   <= rem_d;
      valid_q <= (rem_d != '0);
      coin_q  <= greedy_coin(rem_d);
    end else begin
      valid_q <= 1'b0;
      coin_q  <= COIN_NONE;
    end
  end

  assign valid_o = valid_q;
  assign coin_o  = coin_q;
endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: price check, vend handshake with timeout, change/refund, counter clear.
// Optional VEND_STATS_EN adds a saturating sales_total of acknowledged vends.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE_0      = 10,
  parameter int PRICE_1      = 15,
  parameter int PRICE_2      = 20,
  parameter int PRICE_3      = 25,
  parameter int VEND_TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  credit_t    total_amount,
  input  logic       sel_valid,
  input  logic [1:0] sel_item,
  input  logic       cancel,
  output logic       coin_inhibit,
  output logic       credit_clear,
  output logic       sel_reject,
  output logic       vend_fault,
  output logic       busy,
  vend_if.master     vif
`ifdef VEND_STATS_EN
  , output logic [15:0] sales_total
`endif
);
  localparam int TW = $clog2(VEND_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(VEND_TIMEOUT - 1);

  function automatic credit_t price_of(input logic [1:0] i);
    case (i)
      2'd0:    return credit_t'(PRICE_0);
      2'd1:    return credit_t'(PRICE_1);
      2'd2:    return credit_t'(PRICE_2);
      default: return credit_t'(PRICE_3);
    endcase
  endfunction

  state_e        state_q;
  credit_t       snap_q;
  logic [TW-1:0] timer_q;
  logic          busy_q, clr_q, rej_q, req_q, fault_q;
  logic [1:0]    item_q;
  credit_t       price_sel, ld_val;
  logic          ld, pay_done;

  assign price_sel = price_of(sel_item);

  // Payout reload points: refund, post-vend change, timeout refund, late coin.
  always_comb begin
    ld     = 1'b0;
    ld_val = '0;
    case (state_q)
      IDLE: begin
        if (cancel) begin
          if (total_amount != '0) begin
            ld     = 1'b1;
            ld_val = total_amount;
          end
        end else if (sel_valid && total_amount >= price_sel) begin
          ld     = 1'b1;
          ld_val = total_amount - price_sel;
        end
      end
      VEND: if (!vif.vend_ack && timer_q == T_LAST) begin
        ld     = 1'b1;
        ld_val = snap_q;
      end
      CLEAR: if (total_amount > snap_q) begin
        ld     = 1'b1;
        ld_val = total_amount - snap_q;
      end
      default: ;
    endcase
  end

  change_payout u_pay (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ld),
    .load_val_i (ld_val),
    .en_i       (state_q == CHANGE),
    .ready_i    (vif.change_ready),
    .valid_o    (vif.change_valid),
    .coin_o     (vif.change_coin),
    .done_o     (pay_done)
  );

`ifdef VEND_STATS_EN
  logic [15:0] sales_q;
  logic [16:0] sales_sum;
  assign sales_sum = {1'b0, sales_q} + {12'b0, price_of(item_q)};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      timer_q <= '0;
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
      rej_q   <= 1'b0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
      item_q  <= 2'd0;
`ifdef VEND_STATS_EN
      sales_q <= '0;
`endif
    end else begin
      clr_q   <= 1'b0;
      rej_q   <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cancel) begin
            if (total_amount != '0) begin
              snap_q  <= total_amount;
              busy_q  <= 1'b1;
              state_q <= CHANGE;
            end
          end else if (sel_valid) begin
            if (total_amount >= price_sel) begin
              snap_q  <= total_amount;
              item_q  <= sel_item;
              req_q   <= 1'b1;
              timer_q <= '0;
              busy_q  <= 1'b1;
              state_q <= VEND;
            end else begin
              rej_q <= 1'b1;
            end
          end
        end
        VEND: begin
          if (vif.vend_ack) begin
            req_q   <= 1'b0;
            state_q <= CHANGE;
`ifdef VEND_STATS_EN
            sales_q <= sales_sum[16] ? 16'hFFFF : sales_sum[15:0];
`endif
          end else if (timer_q == T_LAST) begin
            req_q   <= 1'b0;
            fault_q <= 1'b1;
            state_q <= CHANGE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        CHANGE: if (pay_done) state_q <= CLEAR;
        CLEAR: begin
          // A coin counted on the decision cycle is returned before clearing.
          if (total_amount > snap_q) begin
            snap_q  <= total_amount;
            state_q <= CHANGE;
          end else begin
            clr_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign coin_inhibit  = busy_q;
  assign busy          = busy_q;
  assign credit_clear  = clr_q;
  assign sel_reject    = rej_q;
  assign vend_fault    = fault_q;
  assign vif.vend_req  = req_q;
  assign vif.vend_item = item_q;
`ifdef VEND_STATS_EN
  assign sales_total = sales_q;
`endif
endmodule

// File: tb/tb_vend_controller.sv
// Randomized transactions checked against a transaction-level model of the vending rules.
module tb_vend_controller;
  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] total_amount = '0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = '0;
  logic       cancel = 1'b0;
  logic       coin_inhibit, credit_clear, sel_reject, vend_fault, busy;
`ifdef VEND_STATS_EN
  logic [15:0] sales_total;
  int          sales_m = 0;
`endif

  vend_if vif();

  int n_chk = 0, n_fail = 0;
  int vreq_n = 0, fault_n = 0, clr_n = 0, rej_n = 0, coin_n = 0;
  int coin_log[1024];
  logic pv = 1'b0, pr = 1'b0;
  logic [1:0] pc = '0;
  int price_tab[4] = '{10, 15, 20, 25};

  vend_controller dut (
    .clk          (clk),
    .reset        (reset),
    .total_amount (total_amount),
    .sel_valid    (sel_valid),
    .sel_item     (sel_item),
    .cancel       (cancel),
    .coin_inhibit (coin_inhibit),
    .credit_clear (credit_clear),
    .sel_reject   (sel_reject),
    .vend_fault   (vend_fault),
    .busy         (busy),
    .vif          (vif)
`ifdef VEND_STATS_EN
    , .sales_total (sales_total)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hopper: accepts about two coins in three, so stalls are frequent.
  always begin
    @(posedge clk);
    #1;
    vif.change_ready = ($urandom_range(0, 2) != 0);
  end

  always @(negedge clk) begin
    if (reset) begin
      if (vif.vend_req) vreq_n <= vreq_n + 1;
      if (vend_fault)   fault_n <= fault_n + 1;
      if (credit_clear) clr_n <= clr_n + 1;
      if (sel_reject)   rej_n <= rej_n + 1;
      if (vif.change_valid && vif.change_ready) begin
        coin_log[coin_n % 1024] <= int'(vif.change_coin);
        coin_n <= coin_n + 1;
      end
      if (pv && !pr) begin
        chk("stall_valid", int'(vif.change_valid), 1);
        chk("stall_coin", int'(vif.change_coin), int'(pc));
      end
    end
    pv <= vif.change_valid;
    pr <= vif.change_ready;
    pc <= vif.change_coin;
  end

  // mode: 0 select, 1 cancel, 2 select+cancel together; ack_dly<0 means never ack.
  task automatic run_txn(input int credit, input int mode, input int item,
                         input int ack_dly, input int late_in);
    int  price, chg, late, k, v0, f0, c0, r0, n0, got_n;
    bit  accepted, vend, acked;
    int  exp_q[$];
    price    = price_tab[item];
    late     = late_in;
    accepted = 1'b0;
    vend     = 1'b0;
    acked    = 1'b0;
    chg      = 0;
    total_amount = 5'(credit);
    tick();
    v0 = vreq_n; f0 = fault_n; c0 = clr_n; r0 = rej_n; n0 = coin_n;
    sel_valid = (mode != 1);
    cancel    = (mode != 0);
    sel_item  = 2'(item);
    tick();
    sel_valid = 1'b0;
    cancel    = 1'b0;
    if (mode != 0) begin
      accepted = (credit > 0);
      chg      = credit;
    end else if (credit >= price) begin
      accepted = 1'b1;
      vend     = 1'b1;
      acked    = (ack_dly >= 0);
      chg      = acked ? credit - price : credit;
    end
    if (accepted) total_amount = 5'(credit + late);
    else late = 0;
    if (vend) begin
      k = 0;
      while (!vif.vend_req && k < 10) begin
        tick();
        k++;
      end
      if (acked) begin
        repeat (ack_dly) tick();
        vif.vend_ack = 1'b1;
        tick();
        vif.vend_ack = 1'b0;
      end
    end
    if (accepted) begin
      k = 0;
      while (clr_n == c0 && k < 1000) begin
        tick();
        k++;
      end
      total_amount = '0;
    end else begin
      repeat (3) tick();
    end
    tick();
    for (int p = 0; p < 2; p++) begin
      int a;
      a = (p == 0) ? chg : late;
      while (a > 0) begin
        if (a >= 10)     begin exp_q.push_back(3); a -= 10; end
        else if (a >= 5) begin exp_q.push_back(2); a -= 5;  end
        else             begin exp_q.push_back(1); a -= 1;  end
      end
    end
`ifdef VEND_STATS_EN
    if (vend && acked) sales_m = (sales_m + price > 65535) ? 65535 : sales_m + price;
    chk("sales_total", int'(sales_total), sales_m);
`endif
    chk("vend_req_cycles", vreq_n - v0, vend ? (acked ? ack_dly + 1 : TMO) : 0);
    chk("vend_fault", fault_n - f0, (vend && !acked) ? 1 : 0);
    chk("credit_clear", clr_n - c0, accepted ? 1 : 0);
    chk("sel_reject", rej_n - r0, (mode == 0 && credit < price) ? 1 : 0);
    got_n = coin_n - n0;
    chk("coin_count", got_n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_n; i++)
      chk($sformatf("coin%0d", i), coin_log[(n0 + i) % 1024], exp_q[i]);
    chk("busy_end", int'(busy), 0);
    chk("inhibit_end", int'(coin_inhibit), 0);
  endtask

  initial begin
    vif.vend_ack = 1'b0;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_inhibit", int'(coin_inhibit), 0);
    chk("rst_clear", int'(credit_clear), 0);
    chk("rst_reject", int'(sel_reject), 0);
    chk("rst_fault", int'(vend_fault), 0);
    chk("rst_vend_req", int'(vif.vend_req), 0);
    chk("rst_vend_item", int'(vif.vend_item), 0);
    chk("rst_change_valid", int'(vif.change_valid), 0);
    chk("rst_change_coin", int'(vif.change_coin), 0);
`ifdef VEND_STATS_EN
    chk("rst_sales", int'(sales_total), 0);
`endif
    reset = 1'b1;
    tick();

    run_txn(25, 0, 1, 2, 0);
    run_txn(8, 0, 0, 0, 0);
    run_txn(16, 1, 0, 0, 0);
    run_txn(31, 0, 3, -1, 0);
    run_txn(20, 2, 0, 0, 0);

    // Reset while a refund is being paid out.
    total_amount = 5'd31;
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_inhibit", int'(coin_inhibit), 0);
    chk("midrst_valid", int'(vif.change_valid), 0);
    chk("midrst_req", int'(vif.vend_req), 0);
    tick();
    total_amount = '0;
    reset = 1'b1;
`ifdef VEND_STATS_EN
    sales_m = 0;
`endif
    tick();

    run_txn(20, 0, 2, 1, 1);

    for (int t = 0; t < 40; t++) begin
      int cr, md, it, ad, lt, r;
      cr = $urandom_range(0, 31);
      r  = $urandom_range(0, 5);
      md = (r < 4) ? 0 : (r == 4 ? 1 : 2);
      if (md == 2 && cr == 0) md = 0;
      it = $urandom_range(0, 3);
      ad = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
      lt = 0;
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 2);
        lt = (r == 0) ? 1 : (r == 1 ? 5 : 10);
        if (cr + lt > 31) lt = 0;
      end
      run_txn(cr, md, it, ad, lt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
